// File: rtl/inst_buffer.sv
// inst_buffer: three-wide instruction queue between fetch and decode.
// Accepts up to three fetched instructions per cycle, presents the oldest
// three to decode, and re-presents ways held back by the hazard rollback count.
module inst_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned XLEN  = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [2:0]                 if_valid,
    input  logic [3*XLEN-1:0]          if_pc,
    input  logic [3*XLEN-1:0]          if_inst,
    output logic                       if_ready,
    input  logic                       flush,
    input  logic [1:0]                 rollback,
    output logic [2:0]                 id_valid,
    output logic [3*XLEN-1:0]          id_pc,
    output logic [3*XLEN-1:0]          id_inst,
    output logic [2:0]                 id_issued,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  mem_pc   [DEPTH];
    logic [XLEN-1:0]  mem_inst [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [1:0]       limit;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [2:0]       wr_en;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [1:0] popcnt3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

    // Ready depends only on registered occupancy so push never waits on pop.
    assign if_ready = (count_q <= CNT_W'(DEPTH - 3));
    assign count    = count_q;
    assign limit    = 2'd3 - rollback;

    // Present the oldest three entries and derive which ways are consumed.
    always_comb begin
        id_valid  = '0;
        id_pc     = '0;
        id_inst   = '0;
        id_issued = '0;
        rd_ptr    = '0;
        for (int i = 0; i < 3; i++) begin
            if (count_q > CNT_W'(i)) begin
                id_valid[i]              = 1'b1;
                rd_ptr                   = head_q + PTR_W'(i);
                id_pc[i*XLEN +: XLEN]    = mem_pc[rd_ptr];
                id_inst[i*XLEN +: XLEN]  = mem_inst[rd_ptr];
            end
            // Rollback holds the youngest presented ways; flush kills all issue.
            if (id_valid[i] && !flush && (2'(i) < limit)) begin
                id_issued[i] = 1'b1;
            end
        end
    end

    // Pointer and occupancy next state; flush wins over push and pop.
    always_comb begin
        push    = if_ready ? popcnt3(if_valid) : 2'd0;
        pop     = popcnt3(id_issued);
        wr_en   = (if_ready && !flush) ? if_valid : 3'b000;
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; stale contents are masked by count, so no reset is needed.
    always_ff @(posedge clock) begin
        for (int j = 0; j < 3; j++) begin
            if (wr_en[j]) begin
                mem_pc[tail_q + PTR_W'(j)]   <= if_pc[j*XLEN +: XLEN];
                mem_inst[tail_q + PTR_W'(j)] <= if_inst[j*XLEN +: XLEN];
            end
        end
    end

endmodule
